// File: rtl/synth_pkg.sv
// Shared definitions for the DDS oscillator: waveform codes,
// divider/full-scale helpers and the quarter-sine table generator.
package synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_SAW    = 2'd2,
      WAVE_TRI    = 2'd3
   } wave_t;

   function automatic int calc_div(int clk_hz, int sample_hz);
      return clk_hz / sample_hz;
   endfunction

   function automatic int calc_fs(int out_w);
      return (1 << (out_w - 1)) - 1;
   endfunction

   // Taylor series keeps table generation free of math-library calls.
   function automatic int rom_entry(int i, int lut_aw, int out_w);
      real x;
      real term;
      real acc;
      x = 1.5707963267948966 * (real'(i) + 0.5) / real'(1 << lut_aw);
      term = x;
      acc = x;
      for (int k = 1; k < 10; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc = acc + term;
      end
      return $rtoi(real'(calc_fs(out_w)) * acc + 0.5);
   endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table with a registered read port.
// Entries sit on half-steps, so no entry is zero.
module sine_quarter_rom
   import synth_pkg::*;
#(
   parameter int LUT_AW = 8,
   parameter int OUT_W  = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [LUT_AW-1:0] addr,
   output logic [OUT_W-2:0]  data
);

   localparam int DEPTH = 1 << LUT_AW;
   localparam int DW    = OUT_W - 1;

   logic [DW-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = DW'(rom_entry(i, LUT_AW, OUT_W));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) data <= '0;
      else          data <= rom[addr];
   end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS oscillator: divider-paced phase accumulator, four waveforms,
// amplitude scaling and a held valid/ready output with overrun flag.
module dds_wave_gen
   import synth_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int SAMPLE_HZ = 48000,
   parameter int PHASE_W   = 32,
   parameter int LUT_AW    = 8,
   parameter int OUT_W     = 24,
   parameter int AMP_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               phase_sync,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [1:0]         wave_sel,
   input  logic [AMP_W-1:0]   amplitude,
   output logic [OUT_W-1:0]   sample_out,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic               overrun
);

   localparam int DIV   = calc_div(CLK_HZ, SAMPLE_HZ);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW    = OUT_W + AMP_W + 1;

   localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
   localparam logic signed [OUT_W-1:0] FS_V = OUT_W'(calc_fs(OUT_W));
   localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

   logic [CNT_W-1:0]   cnt;
   logic [PHASE_W-1:0] phase;
   logic               sync_pend;
   logic               tick;

   logic               s1_valid;
   logic [PHASE_W-1:0] s1_phase;
   wave_t              s1_sel;
   logic [AMP_W-1:0]   s1_amp;

   logic               s2_valid;
   wave_t              s2_sel;
   logic [AMP_W-1:0]   s2_amp;
   logic               s2_neg;
   logic signed [OUT_W-1:0] s2_shape;

   logic [LUT_AW-1:0]  idx;
   logic [LUT_AW-1:0]  rom_addr;
   logic [OUT_W-2:0]   rom_data;

   logic [OUT_W-2:0]   saw_bits;
   logic [OUT_W-1:0]   tri_r;
   logic [OUT_W-1:0]   tri_t;
   logic signed [OUT_W-1:0] raw;
   logic signed [OUT_W-1:0] shape;

   logic signed [OUT_W-1:0] sine_mag;
   logic signed [OUT_W-1:0] wave;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    scaled;
   logic                    unused_bits;

   assign tick = enable && (cnt == DIV_M1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         phase     <= '0;
         sync_pend <= 1'b0;
         s1_valid  <= 1'b0;
         s1_phase  <= '0;
         s1_sel    <= WAVE_SINE;
         s1_amp    <= '0;
      end else begin
         s1_valid <= tick;
         if (enable) cnt <= (cnt == DIV_M1) ? '0 : cnt + 1'b1;
         if (tick) begin
            s1_phase  <= phase;
            s1_sel    <= wave_t'(wave_sel);
            s1_amp    <= amplitude;
            phase     <= (sync_pend || phase_sync) ? '0 : phase + freq_word;
            sync_pend <= 1'b0;
         end else if (phase_sync) begin
            sync_pend <= 1'b1;
         end
      end
   end

   // Odd quadrants walk the table backwards.
   assign idx      = s1_phase[PHASE_W-3 -: LUT_AW];
   assign rom_addr = s1_phase[PHASE_W-2] ? ~idx : idx;

   sine_quarter_rom #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
   ) u_rom (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (rom_addr),
      .data    (rom_data)
   );

   always_comb begin
      saw_bits = s1_phase[PHASE_W-2 -: OUT_W-1];
      tri_r    = s1_phase[PHASE_W-2 -: OUT_W];
      tri_t    = s1_phase[PHASE_W-1] ? ~tri_r : tri_r;
      raw      = '0;
      unique case (s1_sel)
         WAVE_SQUARE: raw = s1_phase[PHASE_W-1] ? -FS_V : FS_V;
         WAVE_SAW:    raw = {~s1_phase[PHASE_W-1], saw_bits};
         WAVE_TRI:    raw = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
         default:     raw = '0;
      endcase
      shape = (raw == MIN_V) ? -FS_V : raw;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_sel   <= WAVE_SINE;
         s2_amp   <= '0;
         s2_neg   <= 1'b0;
         s2_shape <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_sel   <= s1_sel;
         s2_amp   <= s1_amp;
         s2_neg   <= s1_phase[PHASE_W-1];
         s2_shape <= shape;
      end
   end

   assign sine_mag = $signed({1'b0, rom_data});

   always_comb begin
      wave = s2_shape;
      if (s2_sel == WAVE_SINE) wave = s2_neg ? -sine_mag : sine_mag;
      prod   = PW'(wave) * PW'($signed({1'b0, s2_amp}));
      scaled = prod >>> AMP_W;
   end

   assign unused_bits = ^{s1_phase, scaled};

   // A fresh sample always wins over a pending one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (s2_valid) begin
         sample_out   <= scaled[OUT_W-1:0];
         sample_valid <= 1'b1;
         overrun      <= sample_valid && !sample_ready;
      end else begin
         overrun <= 1'b0;
         if (sample_ready) sample_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Randomised bench for dds_wave_gen against an arithmetic model,
// plus directed waveform, backpressure and reset checks.
module tb_dds_wave_gen;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        phase_sync = 1'b0;
   logic [15:0] freq_word = '0;
   logic [1:0]  wave_sel = '0;
   logic [7:0]  amplitude = '0;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        sample_ready = 1'b0;
   logic        overrun;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dds_wave_gen #(
      .CLK_HZ    (1000),
      .SAMPLE_HZ (100),
      .PHASE_W   (16),
      .LUT_AW    (4),
      .OUT_W     (12),
      .AMP_W     (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .phase_sync   (phase_sync),
      .freq_word    (freq_word),
      .wave_sel     (wave_sel),
      .amplitude    (amplitude),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   task automatic chk(string tag, int got, int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   int rom_t[16];
   initial begin
      for (int i = 0; i < 16; i++)
         rom_t[i] = $rtoi(2047.0 * $sin(3.141592653589793 * (i + 0.5) / 32.0) + 0.5);
   end

   function automatic int ref_sample(int p, int sel, int amp);
      int w;
      int q;
      int i;
      case (sel)
         0: begin
            q = p / 16384;
            i = (p / 1024) % 16;
            if (q % 2 == 1) i = 15 - i;
            w = rom_t[i];
            if (q >= 2) w = -w;
         end
         1: w = (p < 32768) ? 2047 : -2047;
         2: w = p / 16 - 2048;
         default: begin
            i = (p / 8) % 4096;
            if (p >= 32768) i = 4095 - i;
            w = i - 2048;
         end
      endcase
      if (w < -2047) w = -2047;
      return (w * amp) >>> 8;
   endfunction

   typedef struct {
      int due;
      int val;
   } item_t;

   item_t pipe_q[$];
   int    m_edge = 0;
   int    m_cnt = 0;
   int    m_phase = 0;
   bit    m_sync = 0;
   bit    e_valid = 0;
   bit    e_ovr = 0;
   int    e_out = 0;

   // Samples appear two edges after the tick edge that produced them.
   always @(posedge clk or negedge reset_n) begin
      item_t it;
      if (!reset_n) begin
         m_edge = 0;
         m_cnt = 0;
         m_phase = 0;
         m_sync = 0;
         e_valid = 0;
         e_ovr = 0;
         e_out = 0;
         pipe_q.delete();
      end else begin
         m_edge++;
         if (pipe_q.size() > 0 && pipe_q[0].due == m_edge) begin
            e_ovr = e_valid && !sample_ready;
            e_out = pipe_q[0].val;
            e_valid = 1;
            void'(pipe_q.pop_front());
         end else begin
            e_ovr = 0;
            if (sample_ready) e_valid = 0;
         end
         if (enable && m_cnt == DIV - 1) begin
            it.due = m_edge + 2;
            it.val = ref_sample(m_phase, wave_sel, amplitude);
            pipe_q.push_back(it);
            m_phase = (m_sync || phase_sync) ? 0 : (m_phase + freq_word) % 65536;
            m_sync = 0;
            m_cnt = 0;
         end else begin
            if (enable) m_cnt++;
            if (phase_sync) m_sync = 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("mon_valid", sample_valid, e_valid);
      chk("mon_sample", $signed(sample_out), e_out);
      chk("mon_overrun", overrun, e_ovr);
   end

   task automatic get_sample(output int s);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(sample_valid && sample_ready) && k < 40);
      chk("sample_wait", sample_valid && sample_ready, 1);
      s = $signed(sample_out);
   endtask

   task automatic resync(input logic [1:0] sel, input logic [15:0] fw);
      int d;
      wave_sel = sel;
      freq_word = fw;
      phase_sync = 1'b1;
      @(negedge clk);
      phase_sync = 1'b0;
      get_sample(d);
   endtask

   initial begin
      int s[16];
      int n;
      int cnt_ovr;
      int mx;
      int nz;
      bit found;

      repeat (3) @(negedge clk);
      chk("rst_valid", sample_valid, 0);
      chk("rst_out", sample_out, 0);
      chk("rst_ovr", overrun, 0);

      wave_sel = 2'd1;
      freq_word = 16'h4000;
      amplitude = 8'd255;
      sample_ready = 1'b1;
      enable = 1'b1;
      reset_n = 1'b1;

      n = 0;
      found = 0;
      while (!found && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         found = sample_valid;
      end
      chk("first_valid_edge", n, 12);
      s[0] = $signed(sample_out);
      for (int i = 1; i < 4; i++) get_sample(s[i]);
      chk("sq0", s[0], 2039);
      chk("sq1", s[1], 2039);
      chk("sq2", s[2], -2040);
      chk("sq3", s[3], -2040);

      resync(2'd2, 16'h8000);
      for (int i = 0; i < 4; i++) get_sample(s[i]);
      chk("saw0", s[0], -2040);
      chk("saw1", s[1], 0);
      chk("saw2", s[2], -2040);
      chk("saw3", s[3], 0);

      resync(2'd0, 16'h1000);
      for (int i = 0; i < 16; i++) get_sample(s[i]);
      chk("sine_s0", s[0], 99);
      mx = 0;
      nz = 0;
      for (int i = 0; i < 16; i++) begin
         if (s[i] > mx) mx = s[i];
         if (-s[i] > mx) mx = -s[i];
         if (s[i] == 0) nz++;
      end
      for (int i = 0; i < 8; i++) begin
         n = s[i] + s[i + 8];
         chk("sine_antisym", (n >= -1 && n <= 1), 1);
      end
      chk("sine_max", mx <= 2039, 1);
      chk("sine_zeros", nz, 0);

      resync(2'd1, 16'h4000);
      get_sample(n);
      @(negedge clk);
      sample_ready = 1'b0;
      cnt_ovr = 0;
      repeat (20) begin
         @(negedge clk);
         cnt_ovr += int'(overrun);
      end
      chk("ovr_pulses", cnt_ovr, 1);
      chk("ovr_hold_valid", sample_valid, 1);
      sample_ready = 1'b1;
      @(negedge clk);
      chk("accept_drop", sample_valid, 0);

      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         if ($urandom_range(15) == 0) begin
            wave_sel = 2'($urandom);
            amplitude = 8'($urandom);
            case ($urandom_range(3))
               0: freq_word = '0;
               1: freq_word = 16'($urandom);
               2: freq_word = 16'h8000 | 16'($urandom);
               default: freq_word = 16'($urandom_range(4096));
            endcase
         end
         phase_sync = ($urandom_range(29) == 0);
         sample_ready = ($urandom_range(3) != 0);
         enable = ($urandom_range(19) != 0);
      end
      phase_sync = 1'b0;
      enable = 1'b1;
      amplitude = 8'd200;
      wave_sel = 2'd3;

      sample_ready = 1'b0;
      n = 0;
      while (!sample_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_valid", sample_valid, 1);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_valid", sample_valid, 0);
      chk("arst_out", sample_out, 0);
      chk("arst_ovr", overrun, 0);
      @(negedge clk);
      reset_n = 1'b1;
      sample_ready = 1'b1;
      repeat (11) @(negedge clk);
      chk("no_stale_valid", sample_valid, 0);
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
